load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Initiator side of the data-memory port: the CPU's multicycle load/store engine.
- Accepts one load or store per handshake from the core and computes the effective address.
- Checks alignment and bounds locally, then routes the access to main memory (data port) or to the MMIO bus at/above IO_BASE.
- Sequences the one-cycle memory read latency, extends IO read data, and returns a single-cycle response with an error flag.

Parameters:
MEM_AW, 15, memory byte-address width; valid memory range is 0 to 2**MEM_AW-1
IO_BASE, 32'h11000000, first MMIO address; addresses >= IO_BASE go to the IO bus

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
req_valid  in  1  core request valid
req_ready  out  1  unit idle, can accept a request
req_we  in  1  1=store, 0=load
req_base  in  32  rs1 value
req_offset  in  32  sign-extended immediate
req_wdata  in  32  store data (rs2)
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_sign  in  1  1=unsigned, 0=signed (load extension)
resp_valid  out  1  one-cycle completion pulse
resp_data  out  32  extended load data (0 for stores and errors)
resp_err  out  1  misaligned / out-of-bounds / illegal size
mem_rd  out  1  memory read strobe (data port)
mem_wr  out  1  memory write strobe
mem_addr  out  32  latched effective address
mem_wdata  out  32  latched store data, unmodified
mem_size  out  2  latched size
mem_sign  out  1  latched sign
mem_rdata  in  32  memory read data, valid the cycle after mem_rd, already size/sign extended
io_rd  out  1  IO read strobe
io_wr  out  1  IO write strobe
io_addr  out  32  latched effective address
io_wdata  out  32  latched store data
io_rdata  in  32  raw IO word, sampled the cycle after io_rd

Behaviour:
- Reset (rst_n=0 at posedge, any state): state=IDLE; all strobes 0; resp_valid=0, resp_data=0, resp_err=0; latched addr/wdata/size/sign=0. An in-flight access is abandoned with no response.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready=1; all other outputs are idle values.
  - On req_valid: latch ea=req_base+req_offset (32-bit, wraps modulo 2**32), plus we, wdata, size, sign.
  - err = size==11, or (size==01 and ea[0]), or (size==10 and ea[1:0]!=0), or (ea>=2**MEM_AW and ea<IO_BASE).
  - err=1 -> RESP with resp_err=1. err=0 -> ISSUE.
- ISSUE: exactly one strobe is high for this single cycle.
  - ea<IO_BASE: mem_wr=we, mem_rd=!we. Otherwise: io_wr=we, io_rd=!we.
  - Store -> RESP. Load -> WAIT.
- WAIT: capture read data into resp_data, then -> RESP.
  - Memory source: mem_rdata as delivered.
  - IO source: extend io_rdata by the latched size/sign. Byte: bits[7:0]; half: bits[15:0]; sign-extend if sign=0, zero-extend if sign=1; word passes through.
- RESP: resp_valid=1 for one cycle, then -> IDLE. No response backpressure.
  - resp_data/resp_err hold until the next request is accepted.
  - resp_data=0 for stores and for errors.
- req_ready=0 in ISSUE/WAIT/RESP; req_valid is ignored there.
- Latency from the accept edge:
  - error: resp_valid 1 cycle later;
  - store: 2 cycles later;
  - load: 3 cycles later.
  - Back-to-back throughput: one request per 3 (store) / 4 (load) cycles.
- mem_addr/io_addr/mem_wdata/mem_size/mem_sign are driven from latches and are stable from ISSUE through RESP.
- Boundaries:
  - ea=2**MEM_AW-1 with byte size: legal.
  - ea=IO_BASE-1 with byte size: error only if >= 2**MEM_AW.
  - base+offset overflow wraps; for example 0xFFFFFFFC+8 = 0x4 is legal.

Test Plan:
- Memory word 0x100 = 0xDEADBEEF; load base=0xFC, off=4, size=10 -> mem_rd one cycle at addr 0x100; resp_valid 3 cycles after accept; resp_data=0xDEADBEEF, err=0.
- IO load at 0x11000000, io_rdata=0x00000080: size=00, sign=0 -> resp_data=0xFFFFFF80; same with sign=1 -> 0x00000080; half signed with io_rdata=0x1234_8001 -> 0xFFFF8001.
- Store word 0xCAFEF00D to 0x11000004 -> io_wr one cycle, io_addr=0x11000004, io_wdata=0xCAFEF00D, mem_wr stays 0; resp_valid 2 cycles after accept, resp_data=0.
- Halfword load at 0x101; word store at 0x102; size=11 at 0x0; any access at 0x8000 (MEM_AW=15) -> resp_err=1 one cycle after accept; no strobe at any point.
- Wraparound: base=0xFFFFFFFC, off=8, word load -> mem_addr=0x4, no error.
- Reset mid-access: rst_n low during WAIT -> next cycle IDLE, req_ready=1, resp_valid never pulses; a following load completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// Multicycle load/store engine: computes the effective address, checks it,
// and sequences a single access to data memory or the MMIO bus.
module load_store_unit #(
    parameter int          MEM_AW  = 15,
    parameter logic [31:0] IO_BASE = 32'h11000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_base,
    input  logic [31:0] req_offset,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_sign,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [1:0]  mem_size,
    output logic        mem_sign,
    input  logic [31:0] mem_rdata,
    output logic        io_rd,
    output logic        io_wr,
    output logic [31:0] io_addr,
    output logic [31:0] io_wdata,
    input  logic [31:0] io_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t      state_reg, state_next;
    logic [31:0] ea_reg, wdata_reg, resp_data_reg;
    logic [1:0]  size_reg;
    logic        we_reg, sign_reg, io_sel_reg, resp_err_reg;

    logic [31:0] ea_w, io_ext_w;
    logic        oob_w, misalign_w, err_w, accept_w;

    assign ea_w       = req_base + req_offset;
    // The gap between the top of memory and IO_BASE decodes to nothing.
    assign oob_w      = (|ea_w[31:MEM_AW]) && (ea_w < IO_BASE);
    assign misalign_w = ((req_size == 2'b01) && ea_w[0]) ||
                        ((req_size == 2'b10) && (ea_w[1:0] != 2'b00));
    assign err_w      = (req_size == 2'b11) || misalign_w || oob_w;
    assign accept_w   = (state_reg == IDLE) && req_valid;

    always_comb begin
        state_next = state_reg;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        io_rd      = 1'b0;
        io_wr      = 1'b0;
        case (state_reg)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    state_next = err_w ? RESP : ISSUE;
            end
            ISSUE: begin
                mem_wr     = !io_sel_reg &&  we_reg;
                mem_rd     = !io_sel_reg && !we_reg;
                io_wr      =  io_sel_reg &&  we_reg;
                io_rd      =  io_sel_reg && !we_reg;
                state_next = we_reg ? RESP : WAIT;
            end
            WAIT: state_next = RESP;
            RESP: begin
                resp_valid = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Memory returns pre-extended data; the IO bus returns a raw word.
    always_comb begin
        case (size_reg)
            2'b00:   io_ext_w = {{24{!sign_reg && io_rdata[7]}}, io_rdata[7:0]};
            2'b01:   io_ext_w = {{16{!sign_reg && io_rdata[15]}}, io_rdata[15:0]};
            default: io_ext_w = io_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            ea_reg        <= '0;
            wdata_reg     <= '0;
            size_reg      <= '0;
            sign_reg      <= 1'b0;
            we_reg        <= 1'b0;
            io_sel_reg    <= 1'b0;
            resp_data_reg <= '0;
            resp_err_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept_w) begin
                ea_reg        <= ea_w;
                wdata_reg     <= req_wdata;
                size_reg      <= req_size;
                sign_reg      <= req_sign;
                we_reg        <= req_we;
                io_sel_reg    <= (ea_w >= IO_BASE);
                resp_data_reg <= '0;
                resp_err_reg  <= err_w;
            end
            if (state_reg == WAIT)
                resp_data_reg <= io_sel_reg ? io_ext_w : mem_rdata;
        end
    end

    assign resp_data = resp_data_reg;
    assign resp_err  = resp_err_reg;
    assign mem_addr  = ea_reg;
    assign mem_wdata = wdata_reg;
    assign mem_size  = size_reg;
    assign mem_sign  = sign_reg;
    assign io_addr   = ea_reg;
    assign io_wdata  = wdata_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, randomized transactions
// against a byte-addressed reference model, and a reset-during-access sequence.
module tb_load_store_unit;

    localparam int          MEM_AW  = 15;
    localparam logic [31:0] IO_BASE = 32'h11000000;
    localparam int S_NONE = 0, S_MRD = 1, S_MWR = 2, S_IORD = 3, S_IOWR = 4, S_MULTI = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we, req_sign;
    logic [31:0] req_base, req_offset, req_wdata;
    logic [1:0]  req_size;
    logic        resp_valid, resp_err;
    logic [31:0] resp_data;
    logic        mem_rd, mem_wr, mem_sign, io_rd, io_wr;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, io_addr, io_wdata, io_rdata;
    logic [1:0]  mem_size;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] bus_mem [8192];
    logic [31:0] ref_mem [8192];

    typedef struct {
        logic        we;
        logic [31:0] base, off, wdata;
        logic [1:0]  size;
        logic        sign;
        logic [31:0] io_val, exp_data;
        logic        exp_err;
        int          exp_lat;
        int          exp_strobe;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs [20];

    load_store_unit #(.MEM_AW(MEM_AW), .IO_BASE(IO_BASE)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_base(req_base), .req_offset(req_offset), .req_wdata(req_wdata),
        .req_size(req_size), .req_sign(req_sign),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_size(mem_size), .mem_sign(mem_sign), .mem_rdata(mem_rdata),
        .io_rd(io_rd), .io_wr(io_wr), .io_addr(io_addr), .io_wdata(io_wdata),
        .io_rdata(io_rdata)
    );

    always #5 clk = ~clk;

    // Data memory responder: one-cycle read latency, returns extended data.
    function automatic logic [31:0] bus_read(input logic [31:0] a, input logic [1:0] sz, input logic sg);
        logic [31:0] w;
        w = bus_mem[a[14:2]] >> {a[1:0], 3'b000};
        case (sz)
            2'b00:   return {{24{!sg && w[7]}}, w[7:0]};
            2'b01:   return {{16{!sg && w[15]}}, w[15:0]};
            default: return w;
        endcase
    endfunction

    always @(posedge clk) begin
        if (mem_rd)
            mem_rdata <= bus_read(mem_addr, mem_size, mem_sign);
        if (mem_wr) begin
            case (mem_size)
                2'b00:   bus_mem[mem_addr[14:2]][{mem_addr[1:0], 3'b000} +: 8] <= mem_wdata[7:0];
                2'b01:   bus_mem[mem_addr[14:2]][{mem_addr[1], 4'b0000} +: 16] <= mem_wdata[15:0];
                default: bus_mem[mem_addr[14:2]] <= mem_wdata;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        return 8'(ref_mem[a[14:2]] >> ((a % 4) * 8));
    endfunction

    // Reference model: byte-addressed, rules applied straight from the address map.
    function automatic void ref_txn(inout vec_t v);
        logic [31:0] ea, val;
        int          n, sh;
        ea = v.base + v.off;
        n  = (v.size == 2'b11) ? 0 : (1 << v.size);
        v.exp_addr = ea;
        v.exp_data = 32'h0;
        if (n == 0)
            v.exp_err = 1'b1;
        else
            v.exp_err = ((ea % n) != 0) || (ea >= (32'd1 << MEM_AW) && ea < IO_BASE);
        if (v.exp_err) begin
            v.exp_lat    = 1;
            v.exp_strobe = S_NONE;
        end else if (v.we) begin
            v.exp_lat    = 2;
            v.exp_strobe = (ea >= IO_BASE) ? S_IOWR : S_MWR;
            if (ea < IO_BASE) begin
                for (int i = 0; i < n; i++) begin
                    sh = ((ea + i) % 4) * 8;
                    ref_mem[ea[14:2]] = (ref_mem[ea[14:2]] & ~(32'hFF << sh)) |
                                        (((v.wdata >> (8 * i)) & 32'hFF) << sh);
                end
            end
        end else begin
            v.exp_lat    = 3;
            v.exp_strobe = (ea >= IO_BASE) ? S_IORD : S_MRD;
            if (ea >= IO_BASE) begin
                val = v.io_val;
            end else begin
                val = 32'h0;
                for (int i = 0; i < n; i++)
                    val = val | (32'(ref_byte(ea + i)) << (8 * i));
            end
            if (n < 4) begin
                val = val & ((32'd1 << (8 * n)) - 1);
                if (!v.sign && val[8 * n - 1])
                    val = val | ~((32'd1 << (8 * n)) - 1);
            end
            v.exp_data = val;
        end
    endfunction

    // Called at a negedge; returns at a negedge one cycle after the response.
    task automatic run_txn(input string tag, input vec_t v);
        int lat, kind, nstb, nb, ready_busy;
        logic [31:0] saddr, swd, rdata;
        logic rerr;
        for (int w = 0; w < 10 && !req_ready; w++) @(negedge clk);
        check({tag, " ready"}, 32'(req_ready), 32'd1);
        io_rdata   = v.io_val;
        req_valid  = 1'b1;
        req_we     = v.we;
        req_base   = v.base;
        req_offset = v.off;
        req_wdata  = v.wdata;
        req_size   = v.size;
        req_sign   = v.sign;
        @(posedge clk);
        lat = 0; kind = S_NONE; nstb = 0; ready_busy = 0;
        saddr = 32'h0; swd = 32'h0; rdata = 32'h0; rerr = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req_valid = 1'b0;
                req_base  = $urandom;
            end
            nb = int'(mem_rd) + int'(mem_wr) + int'(io_rd) + int'(io_wr);
            if (nb != 0) begin
                nstb += nb;
                if (nb > 1)      kind = S_MULTI;
                else if (mem_rd) kind = S_MRD;
                else if (mem_wr) kind = S_MWR;
                else if (io_rd)  kind = S_IORD;
                else             kind = S_IOWR;
                saddr = (mem_rd || mem_wr) ? mem_addr : io_addr;
                swd   = mem_wr ? mem_wdata : io_wdata;
            end
            if (req_ready) ready_busy++;
            if (resp_valid) begin
                lat   = k;
                rdata = resp_data;
                rerr  = resp_err;
                break;
            end
        end
        check({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
        check({tag, " resp_err"}, 32'(rerr), 32'(v.exp_err));
        check({tag, " resp_data"}, rdata, v.exp_data);
        check({tag, " strobe"}, 32'(kind), 32'(v.exp_strobe));
        check({tag, " strobe_cycles"}, 32'(nstb), (v.exp_strobe == S_NONE) ? 32'd0 : 32'd1);
        check({tag, " busy_ready"}, 32'(ready_busy), 32'd0);
        if (v.exp_strobe != S_NONE)
            check({tag, " addr"}, saddr, v.exp_addr);
        if (v.exp_strobe == S_MWR || v.exp_strobe == S_IOWR)
            check({tag, " wdata"}, swd, v.wdata);
        @(negedge clk);
        check({tag, " pulse_end"}, 32'(resp_valid), 32'd0);
        check({tag, " data_hold"}, resp_data, v.exp_data);
        check({tag, " err_hold"}, 32'(resp_err), 32'(v.exp_err));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        logic [31:0] ea;
        int region, bad_pulse;

        vecs[0]  = '{1'b0, 32'h000000FC, 32'h4,        32'h0,        2'd2, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0, 3, S_MRD,  32'h00000100};
        vecs[1]  = '{1'b0, 32'h11000000, 32'h0,        32'h0,        2'd0, 1'b0, 32'h00000080, 32'hFFFFFF80, 1'b0, 3, S_IORD, 32'h11000000};
        vecs[2]  = '{1'b0, 32'h11000000, 32'h0,        32'h0,        2'd0, 1'b1, 32'h00000080, 32'h00000080, 1'b0, 3, S_IORD, 32'h11000000};
        vecs[3]  = '{1'b0, 32'h11000000, 32'h0,        32'h0,        2'd1, 1'b0, 32'h12348001, 32'hFFFF8001, 1'b0, 3, S_IORD, 32'h11000000};
        vecs[4]  = '{1'b1, 32'h11000000, 32'h4,        32'hCAFEF00D, 2'd2, 1'b0, 32'h0,        32'h0,        1'b0, 2, S_IOWR, 32'h11000004};
        vecs[5]  = '{1'b0, 32'h00000101, 32'h0,        32'h0,        2'd1, 1'b0, 32'h0,        32'h0,        1'b1, 1, S_NONE, 32'h0};
        vecs[6]  = '{1'b1, 32'h00000100, 32'h2,        32'h11111111, 2'd2, 1'b0, 32'h0,        32'h0,        1'b1, 1, S_NONE, 32'h0};
        vecs[7]  = '{1'b0, 32'h00000000, 32'h0,        32'h0,        2'd3, 1'b0, 32'h0,        32'h0,        1'b1, 1, S_NONE, 32'h0};
        vecs[8]  = '{1'b0, 32'h00008000, 32'h0,        32'h0,        2'd0, 1'b0, 32'h0,        32'h0,        1'b1, 1, S_NONE, 32'h0};
        vecs[9]  = '{1'b1, 32'h00007000, 32'h1000,     32'h000000AA, 2'd0, 1'b0, 32'h0,        32'h0,        1'b1, 1, S_NONE, 32'h0};
        vecs[10] = '{1'b0, 32'hFFFFFFFC, 32'h8,        32'h0,        2'd2, 1'b0, 32'h0,        32'h5A000001, 1'b0, 3, S_MRD,  32'h00000004};
        vecs[11] = '{1'b1, 32'h00000200, 32'h0,        32'h12345678, 2'd2, 1'b0, 32'h0,        32'h0,        1'b0, 2, S_MWR,  32'h00000200};
        vecs[12] = '{1'b0, 32'h00000203, 32'h0,        32'h0,        2'd0, 1'b1, 32'h0,        32'h00000012, 1'b0, 3, S_MRD,  32'h00000203};
        vecs[13] = '{1'b0, 32'h00000200, 32'h0,        32'h0,        2'd1, 1'b0, 32'h0,        32'h00005678, 1'b0, 3, S_MRD,  32'h00000200};
        vecs[14] = '{1'b0, 32'h00007FFF, 32'h0,        32'h0,        2'd0, 1'b0, 32'h0,        32'h0000005A, 1'b0, 3, S_MRD,  32'h00007FFF};
        vecs[15] = '{1'b0, 32'h10FFFFFF, 32'h0,        32'h0,        2'd0, 1'b0, 32'h0,        32'h0,        1'b1, 1, S_NONE, 32'h0};
        vecs[16] = '{1'b0, 32'h00000210, 32'hFFFFFFF0, 32'h0,        2'd2, 1'b0, 32'h0,        32'h12345678, 1'b0, 3, S_MRD,  32'h00000200};
        vecs[17] = '{1'b0, 32'h11000010, 32'h0,        32'h0,        2'd2, 1'b1, 32'h89ABCDEF, 32'h89ABCDEF, 1'b0, 3, S_IORD, 32'h11000010};
        vecs[18] = '{1'b1, 32'h00007FFE, 32'h0,        32'hAABBCC80, 2'd0, 1'b0, 32'h0,        32'h0,        1'b0, 2, S_MWR,  32'h00007FFE};
        vecs[19] = '{1'b0, 32'h00007FFE, 32'h0,        32'h0,        2'd0, 1'b0, 32'h0,        32'hFFFFFF80, 1'b0, 3, S_MRD,  32'h00007FFE};

        for (int i = 0; i < 8192; i++) begin
            bus_mem[i] = 32'h5A000000 | 32'(i);
            ref_mem[i] = 32'h5A000000 | 32'(i);
        end
        bus_mem[32'h40] = 32'hDEADBEEF;
        ref_mem[32'h40] = 32'hDEADBEEF;

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_base = '0; req_offset = '0;
        req_wdata = '0; req_size = '0; req_sign = 1'b0; io_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset req_ready", 32'(req_ready), 32'd1);
        check("reset resp_valid", 32'(resp_valid), 32'd0);
        check("reset strobes", {28'd0, mem_rd, mem_wr, io_rd, io_wr}, 32'd0);
        check("reset mem_addr", mem_addr, 32'h0);
        check("reset resp_data", resp_data, 32'h0);
        check("reset resp_err", 32'(resp_err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 20; i++) begin
            v = vecs[i];
            ref_txn(v);
            run_txn($sformatf("vec%0d", i), vecs[i]);
        end

        for (int i = 0; i < 200; i++) begin
            region = $urandom_range(0, 9);
            v.we     = 1'($urandom_range(0, 1));
            v.size   = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            v.sign   = 1'($urandom_range(0, 1));
            v.wdata  = $urandom;
            v.io_val = $urandom;
            if (region <= 5)      ea = $urandom_range(0, 32'h7FFF);
            else if (region <= 7) ea = IO_BASE + $urandom_range(0, 255);
            else if (region == 8) ea = $urandom_range(32'h8000, 32'h10FFFFFF);
            else                  ea = $urandom;
            if (v.size != 2'd3 && $urandom_range(0, 3) != 0)
                ea = ea & ~((32'd1 << v.size) - 1);
            v.base = $urandom;
            v.off  = ea - v.base;
            ref_txn(v);
            run_txn($sformatf("rnd%0d", i), v);
        end

        // Reset while a load sits in WAIT: abandoned without a response.
        req_valid = 1'b1; req_we = 1'b0; req_base = 32'h300; req_offset = 32'h0;
        req_size = 2'd2; req_sign = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rstmid req_ready", 32'(req_ready), 32'd1);
        check("rstmid resp_valid", 32'(resp_valid), 32'd0);
        check("rstmid mem_addr", mem_addr, 32'h0);
        check("rstmid resp_data", resp_data, 32'h0);
        rst_n = 1'b1;
        bad_pulse = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (resp_valid) bad_pulse++;
        end
        check("rstmid no_pulse", 32'(bad_pulse), 32'd0);
        v = '{1'b0, 32'h300, 32'h0, 32'h0, 2'd2, 1'b0, 32'h0, 32'h0, 1'b0, 0, S_NONE, 32'h0};
        ref_txn(v);
        run_txn("after_reset", v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
